btb_update: RTL

Branch-resolution side of the branch target buffer. Sits at the end of the execute stage. It performs these steps:
- Compares each resolved branch/jump against the prediction carried down the pipe from fetch.
- Raises a registered front-end redirect on mispredict.
- Keeps a 2-bit hysteresis counter per BTB index.
- Queues BTB write/remove commands in a small FIFO and drains them one per cycle into the BTB write port.

---
 rtl/btb_update.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/btb_update.sv
// Branch-resolution side of the BTB: mispredict detection, registered redirect,
// 2-bit hysteresis counters and an in-order update FIFO draining into the BTB write port.
module btb_update #(
  parameter int IDX_W  = 10,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_un_j,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_hit,
  input  logic [31:0]      ex_pred_target,
  input  logic [IDX_W-1:0] ex_pred_index,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             btb_wen,
  output logic             btb_remove,
  output logic [IDX_W-1:0] btb_index_w,
  output logic             btb_un_j_w,
  output logic [31:0]      btb_pc_w,
  output logic [31:0]      btb_target_w
);

  localparam int PTR_W   = $clog2(QDEPTH);
  localparam int NUM_ENT = 1 << IDX_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QDEPTH);

  typedef enum logic {
    CMD_WRITE  = 1'b0,
    CMD_REMOVE = 1'b1
  } cmd_kind_e;

  typedef struct packed {
    cmd_kind_e        kind;
    logic [IDX_W-1:0] index;
    logic             un_j;
    logic [31:0]      pc;
    logic [31:0]      target;
  } btb_cmd_t;

  // State
  logic             rdy_q, rdy_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [1:0]       cnt_q [NUM_ENT];
  btb_cmd_t         fifo_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Resolution datapath
  logic       fifo_full;
  logic       fifo_pop;
  logic       accept;
  logic       taken_eff;
  logic       tgt_match;
  logic       mispredict;
  logic [1:0] cnt_cur;
  logic [1:0] cnt_d;
  logic       cnt_we;
  logic       push;
  btb_cmd_t   push_cmd;
  btb_cmd_t   head;
  logic       head_valid;

  assign fifo_full  = (count_q == FULL_CNT);
  assign ex_ready   = rdy_q && !fifo_full;
  assign accept     = ex_valid && ex_ready;
  assign taken_eff  = ex_taken | ex_un_j;
  assign tgt_match  = (ex_pred_target == ex_target);
  assign mispredict = (taken_eff && (!ex_pred_hit || !tgt_match)) || (!taken_eff && ex_pred_hit);
  assign cnt_cur    = cnt_q[ex_pred_index];
  assign head_valid = (count_q != '0);
  assign head       = fifo_q[rd_ptr_q];
  assign fifo_pop   = head_valid;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_we   = 1'b0;
    cnt_d    = cnt_cur;
    push     = 1'b0;
    push_cmd = '0;
    if (accept) begin
      if (taken_eff && (!ex_pred_hit || !tgt_match)) begin
        push     = 1'b1;
        push_cmd = '{kind: CMD_WRITE, index: ex_pred_index, un_j: ex_un_j,
                     pc: ex_pc, target: ex_target};
        cnt_we   = 1'b1;
        cnt_d    = 2'b10;
      end else if (taken_eff) begin
        cnt_we = 1'b1;
        cnt_d  = (cnt_cur == 2'b11) ? 2'b11 : cnt_cur + 2'd1;
      end else if (ex_pred_hit && cnt_cur <= 2'b01) begin
        push     = 1'b1;
        push_cmd = '{kind: CMD_REMOVE, index: ex_pred_index, un_j: 1'b0,
                     pc: 32'd0, target: 32'd0};
        cnt_we   = 1'b1;
        cnt_d    = 2'b00;
      end else if (ex_pred_hit) begin
        cnt_we = 1'b1;
        cnt_d  = cnt_cur - 2'd1;
      end
    end
  end

  always_comb begin
    rdy_d         = 1'b1;
    redirect_d    = accept && mispredict;
    redirect_pc_d = redirect_pc_q;
    if (accept && mispredict) begin
      redirect_pc_d = taken_eff ? ex_target : ex_pc + 32'd8;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (fifo_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(fifo_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q         <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      rdy_q         <= rdy_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // NOTE: counters must read 00 after reset so they are reset; FIFO payload is not,
  // because an empty count already masks every stale slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENT; i++) cnt_q[i] <= 2'b00;
    end else if (cnt_we) begin
      cnt_q[ex_pred_index] <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_cmd;
  end

  // BTB port is driven straight from the head; removes carry only the index.
  assign btb_wen      = head_valid && (head.kind == CMD_WRITE);
  assign btb_remove   = head_valid && (head.kind == CMD_REMOVE);
  assign btb_index_w  = head_valid ? head.index : '0;
  assign btb_un_j_w   = btb_wen ? head.un_j : 1'b0;
  assign btb_pc_w     = btb_wen ? head.pc : '0;
  assign btb_target_w = btb_wen ? head.target : '0;

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule
